inertial_interface: RTL and testbench
=====================================

# inertial_interface

Producer side of the inertial datapath. At power-up it configures the 6-axis IMU over SPI. On each IMU data-ready interrupt it reads the pitch-rate and Z-acceleration registers, then presents `ptch_rt`, `AZ` and a one-cycle `vld` strobe to `inertial_integrator`. It contains the SPI master and the command sequencer, and sits between the IMU pins and the integrator.

## Interface
- `INIT_WAIT_BITS`, default 16: width of the power-up wait timer. The block waits 2^INIT_WAIT_BITS clocks before configuring the IMU. Benches shorten it.
- `SCLK_DIV_BITS`, default 5: width of the SCLK divider. SCLK period is 2^SCLK_DIV_BITS clocks.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `INT`  in  1  IMU data-ready, level high, asynchronous to `clk`.
- `MISO`  in  1  SPI data from the IMU.
- `SS_n`  out  1  SPI slave select, active low.
- `SCLK`  out  1  SPI clock; idles high.
- `MOSI`  out  1  SPI data to the IMU.
- `vld`  out  1  one-cycle strobe: new `ptch_rt`/`AZ` available.
- `ptch_rt`  out  16  raw signed pitch rate, {high byte, low byte}.
- `AZ`  out  16  raw signed Z acceleration, {high byte, low byte}.

## Operation
- `INT` passes through a 2-flop synchronizer before any use.
- Sequencer states: INIT_WAIT, CFG0..CFG3, WAIT_INT, RD_PL, RD_PH, RD_AL, RD_AH, DONE.
- INIT_WAIT: the free-running timer counts to all-ones, then the sequencer moves to CFG0.
- CFG0..CFG3 write 0x0D02 (INT enable), 0x1053 (accel 208 Hz, ±2 g), 0x1150 (gyro 208 Hz, 245 dps), 0x1460 (rounding), in that order. Each state issues one transaction and advances on that transaction's `done`.
- WAIT_INT: when the synchronized INT is high, go to RD_PL.
- Read states issue 0xA200 (pitch L), 0xA300 (pitch H), 0xAC00 (AZ L), 0xAD00 (AZ H), in that order. Each returned low byte (`rd_data[7:0]`) is captured into a holding register on that transaction's `done`.
- DONE, one cycle: load `ptch_rt` and `AZ` from the holding registers simultaneously, pulse `vld`, return to WAIT_INT.
- `ptch_rt`/`AZ` change only in DONE. Between updates they hold their last values.
- Partial samples are never visible on the outputs.
- INT is level-sensitive. If INT is still high on return to WAIT_INT, a new read sequence starts on the next cycle.
- INT edges during CFG or read states are ignored; no queueing.
- Reset values: SS_n=1, SCLK=1, MOSI=0, vld=0, ptch_rt=0x0000, AZ=0x0000, state=INIT_WAIT, timer=0.
- Reset asserted mid-transaction:
  - SS_n and SCLK go high immediately, asynchronously.
  - The partial read is discarded.
  - Configuration restarts from INIT_WAIT.

## Timing
SPI master, mode 3, 16-bit frames, MSB first:
- `wrt` drives SS_n low on the next clock. The divider loads 0b10111 (scaled to SCLK_DIV_BITS), so the first SCLK fall occurs 8 clocks after SS_n falls.
- MOSI changes on SCLK fall. MISO is sampled on SCLK rise and shifted in on the following fall.
- After the 16th rise, the point where the 17th fall would occur raises SS_n and SCLK stays high. `done` pulses one cycle, and `rd_data` is valid in that same cycle.
- With default SCLK_DIV_BITS, one transaction takes 16×32+8 = 520 clocks; SS_n low time is constant.
- Consecutive transactions have at least 1 clock of SS_n high.

Latencies:
- INT rise to `vld`: 2 synchronizer cycles + 4 transactions + sequencer overhead, at most 2100 clocks at defaults.
- `vld` is asserted exactly one cycle per read sequence, never during CFG states.
- Outputs are registered; no combinational path from inputs.

## Structure
- Package `inertial_pkg` holds:
  - the sequencer state enum;
  - the 4 configuration command words;
  - the 4 read command words;
  - the shared PTCH_RT_OFFSET constant consumed by `inertial_integrator`.
- Sub-module `SPI_mstr16` contains the SCLK divider, 16-bit shift register, bit counter and SS_n/done logic. It has ports `clk`, `rst_n`, `wrt`, `cmd[15:0]`, `done`, `rd_data[15:0]`, `SS_n`, `SCLK`, `MOSI`, `MISO`.
- The top holds the synchronizer, init timer, sequencer and holding/output registers.

## Test plan
The bench uses an SPI slave IMU model and INIT_WAIT_BITS=8.
- Reset: immediately after rst_n falls, SS_n=1, SCLK=1, vld=0, ptch_rt=AZ=0. No SS_n activity for 256 clocks after release.
- Init: slave captures exactly 0x0D02, 0x1053, 0x1150, 0x1460 in order. SCLK period is 32 clocks. The first fall is 8 clocks after SS_n low. vld stays 0 throughout.
- Read: model returns 0x34, 0x12, 0x78, 0x56 for A2/A3/AC/AD, then INT pulses. Commands seen are 0xA200, 0xA300, 0xAC00, 0xAD00. Result: ptch_rt=0x1234, AZ=0x5678, with vld high exactly one cycle. Outputs are unchanged before that cycle.
- INT handling:
  - INT held high: back-to-back sequences, one vld each.
  - INT pulsed during RD_PH: no extra sequence and no extra vld.
- Reset mid-read: rst_n low during the AL transaction forces SS_n=1 asynchronously. After release, outputs are 0 and the full init sequence repeats before any read.
- Sign/width: model returns 0x00, 0xF0, 0xFF, 0x80, giving ptch_rt=0xF000 and AZ=0x80FF (byte order intact).

Source files
------------

// File: rtl/inertial_pkg.sv
// Shared definitions for the inertial datapath: sequencer states, IMU command words
// and the pitch-rate offset used downstream by the integrator.
package inertial_pkg;

    typedef enum logic [3:0] {
        INIT_WAIT = 4'd0,
        CFG0      = 4'd1,
        CFG1      = 4'd2,
        CFG2      = 4'd3,
        CFG3      = 4'd4,
        WAIT_INT  = 4'd5,
        RD_PL     = 4'd6,
        RD_PH     = 4'd7,
        RD_AL     = 4'd8,
        RD_AH     = 4'd9,
        DONE      = 4'd10
    } seq_state_e;

    localparam logic [15:0] CFG_CMD_INT_EN = 16'h0D02;
    localparam logic [15:0] CFG_CMD_ACCEL  = 16'h1053;
    localparam logic [15:0] CFG_CMD_GYRO   = 16'h1150;
    localparam logic [15:0] CFG_CMD_ROUND  = 16'h1460;

    localparam logic [15:0] RD_CMD_PTCH_L  = 16'hA200;
    localparam logic [15:0] RD_CMD_PTCH_H  = 16'hA300;
    localparam logic [15:0] RD_CMD_AZ_L    = 16'hAC00;
    localparam logic [15:0] RD_CMD_AZ_H    = 16'hAD00;

    localparam logic signed [15:0] PTCH_RT_OFFSET = 16'sh0050;

    // Command word issued by each transaction-bearing state; idle states map to zero.
    function automatic logic [15:0] seq_cmd(input seq_state_e s);
        logic [15:0] c;
        case (s)
            CFG0:    c = CFG_CMD_INT_EN;
            CFG1:    c = CFG_CMD_ACCEL;
            CFG2:    c = CFG_CMD_GYRO;
            CFG3:    c = CFG_CMD_ROUND;
            RD_PL:   c = RD_CMD_PTCH_L;
            RD_PH:   c = RD_CMD_PTCH_H;
            RD_AL:   c = RD_CMD_AZ_L;
            RD_AH:   c = RD_CMD_AZ_H;
            default: c = 16'h0000;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/inertial_interface_if.sv
// IMU pin bundle plus the sample bus toward the integrator.
interface inertial_interface_if;
    logic        INT;
    logic        MISO;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        vld;
    logic [15:0] ptch_rt;
    logic [15:0] AZ;

    modport master (
        input  INT, MISO,
        output SS_n, SCLK, MOSI, vld, ptch_rt, AZ
    );

    modport slave (
        output INT, MISO,
        input  SS_n, SCLK, MOSI, vld, ptch_rt, AZ
    );
endinterface

// File: rtl/SPI_mstr16.sv
// Mode-3 16-bit SPI master: SCLK divider, shift register, bit counter, SS_n/done.
module SPI_mstr16 #(
    parameter int SCLK_DIV_BITS = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wrt,
    input  logic [15:0] cmd,
    output logic        done,
    output logic [15:0] rd_data,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);

    localparam int DW = SCLK_DIV_BITS;
    // Preload puts the first SCLK fall 8 clocks after SS_n drops.
    localparam logic [DW-1:0] DIV_LOAD = {1'b1, 1'b0, {(DW-2){1'b1}}};
    localparam logic [DW-1:0] DIV_FALL = {DW{1'b1}};
    localparam logic [DW-1:0] DIV_RISE = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] DIV_ONE  = {{(DW-1){1'b0}}, 1'b1};

    logic          active_q;
    logic [DW-1:0] div_q;
    logic [DW-1:0] div_d;
    logic [4:0]    bit_cnt_q;
    logic [15:0]   shft_q;
    logic          miso_smpl_q;
    logic          ss_n_q;
    logic          sclk_q;
    logic          mosi_q;
    logic          done_q;
    logic          fall_s;
    logic          rise_s;
    logic          last_s;

    // Divider next value and the SCLK edge events it implies.
    always_comb begin
        div_d  = div_q + DIV_ONE;
        fall_s = active_q && (div_d == DIV_FALL);
        rise_s = active_q && (div_d == DIV_RISE);
        last_s = fall_s && (bit_cnt_q == 5'd16);
    end

    // Transaction engine; the 17th fall point closes the frame instead of toggling SCLK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q    <= 1'b0;
            div_q       <= {DW{1'b0}};
            bit_cnt_q   <= 5'd0;
            shft_q      <= 16'h0000;
            miso_smpl_q <= 1'b0;
            ss_n_q      <= 1'b1;
            sclk_q      <= 1'b1;
            mosi_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (!active_q) begin
                if (wrt) begin
                    active_q  <= 1'b1;
                    ss_n_q    <= 1'b0;
                    div_q     <= DIV_LOAD;
                    bit_cnt_q <= 5'd0;
                    shft_q    <= cmd;
                end
            end else begin
                div_q <= div_d;
                if (rise_s) begin
                    sclk_q      <= 1'b1;
                    miso_smpl_q <= MISO;
                end
                if (fall_s) begin
                    shft_q <= {shft_q[14:0], miso_smpl_q};
                    if (last_s) begin
                        active_q <= 1'b0;
                        ss_n_q   <= 1'b1;
                        done_q   <= 1'b1;
                    end else begin
                        sclk_q    <= 1'b0;
                        mosi_q    <= shft_q[15];
                        bit_cnt_q <= bit_cnt_q + 5'd1;
                    end
                end
            end
        end
    end

    assign done    = done_q;
    assign rd_data = shft_q;
    assign SS_n    = ss_n_q;
    assign SCLK    = sclk_q;
    assign MOSI    = mosi_q;

endmodule

// File: rtl/inertial_interface.sv
// IMU configuration and sample-read sequencer; presents pitch rate and Z accel with a vld strobe.
module inertial_interface
    import inertial_pkg::*;
#(
    parameter int INIT_WAIT_BITS = 16,
    parameter int SCLK_DIV_BITS  = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    inertial_interface_if.master imu
);

    localparam int TW = INIT_WAIT_BITS;
    localparam logic [TW-1:0] TIMER_MAX = {TW{1'b1}};
    localparam logic [TW-1:0] TIMER_ONE = {{(TW-1){1'b0}}, 1'b1};

    logic          int_meta_q;
    logic          int_sync_q;
    logic [TW-1:0] timer_q;
    seq_state_e    state_q;
    logic          wrt_q;
    logic [7:0]    pl_q;
    logic [7:0]    ph_q;
    logic [7:0]    al_q;
    logic [7:0]    ah_q;
    logic [15:0]   ptch_rt_q;
    logic [15:0]   az_q;
    logic          vld_q;
    logic [15:0]   cmd_s;
    logic          spi_done_s;
    logic [15:0]   spi_rd_data_s;

    // Two-flop synchronizer for the asynchronous data-ready line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_meta_q <= 1'b0;
            int_sync_q <= 1'b0;
        end else begin
            int_meta_q <= imu.INT;
            int_sync_q <= int_meta_q;
        end
    end

    // wrt is raised on entry to a state, so the command tracks the current state.
    always_comb begin
        cmd_s = seq_cmd(state_q);
    end

    SPI_mstr16 #(
        .SCLK_DIV_BITS(SCLK_DIV_BITS)
    ) u_spi (
        .clk     (clk),
        .rst_n   (rst_n),
        .wrt     (wrt_q),
        .cmd     (cmd_s),
        .done    (spi_done_s),
        .rd_data (spi_rd_data_s),
        .SS_n    (imu.SS_n),
        .SCLK    (imu.SCLK),
        .MOSI    (imu.MOSI),
        .MISO    (imu.MISO)
    );

    // Sequencer: power-up wait, four config writes, then one four-register read per INT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= INIT_WAIT;
            timer_q   <= {TW{1'b0}};
            wrt_q     <= 1'b0;
            vld_q     <= 1'b0;
            pl_q      <= 8'h00;
            ph_q      <= 8'h00;
            al_q      <= 8'h00;
            ah_q      <= 8'h00;
            ptch_rt_q <= 16'h0000;
            az_q      <= 16'h0000;
        end else begin
            wrt_q <= 1'b0;
            vld_q <= 1'b0;
            case (state_q)
                INIT_WAIT: begin
                    if (timer_q == TIMER_MAX) begin
                        state_q <= CFG0;
                        wrt_q   <= 1'b1;
                    end else begin
                        timer_q <= timer_q + TIMER_ONE;
                    end
                end
                CFG0: if (spi_done_s) begin state_q <= CFG1; wrt_q <= 1'b1; end
                CFG1: if (spi_done_s) begin state_q <= CFG2; wrt_q <= 1'b1; end
                CFG2: if (spi_done_s) begin state_q <= CFG3; wrt_q <= 1'b1; end
                CFG3: if (spi_done_s) begin state_q <= WAIT_INT; end
                WAIT_INT: begin
                    if (int_sync_q) begin
                        state_q <= RD_PL;
                        wrt_q   <= 1'b1;
                    end
                end
                RD_PL: begin
                    if (spi_done_s) begin
                        pl_q    <= spi_rd_data_s[7:0];
                        state_q <= RD_PH;
                        wrt_q   <= 1'b1;
                    end
                end
                RD_PH: begin
                    if (spi_done_s) begin
                        ph_q    <= spi_rd_data_s[7:0];
                        state_q <= RD_AL;
                        wrt_q   <= 1'b1;
                    end
                end
                RD_AL: begin
                    if (spi_done_s) begin
                        al_q    <= spi_rd_data_s[7:0];
                        state_q <= RD_AH;
                        wrt_q   <= 1'b1;
                    end
                end
                RD_AH: begin
                    if (spi_done_s) begin
                        ah_q    <= spi_rd_data_s[7:0];
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    ptch_rt_q <= {ph_q, pl_q};
                    az_q      <= {ah_q, al_q};
                    vld_q     <= 1'b1;
                    state_q   <= WAIT_INT;
                end
                default: begin
                    state_q <= INIT_WAIT;
                    timer_q <= {TW{1'b0}};
                end
            endcase
        end
    end

    assign imu.vld     = vld_q;
    assign imu.ptch_rt = ptch_rt_q;
    assign imu.AZ      = az_q;

endmodule

// File: tb/tb_inertial_interface.sv
// Directed bench for inertial_interface with a behavioural mode-3 IMU slave.
module tb_inertial_interface;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    inertial_interface_if imu ();

    inertial_interface #(
        .INIT_WAIT_BITS(8),
        .SCLK_DIV_BITS (5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .imu   (imu)
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // IMU slave model
    logic [7:0]  m_pl, m_ph, m_al, m_ah;
    logic [15:0] rx_sh;
    logic [7:0]  tx_b;
    int          fall_n;
    logic [15:0] frames[$];
    int          ssn_falls = 0;
    time         t_ss, t_f1, t_f2;

    function automatic logic [7:0] lookup(input logic [7:0] a);
        case (a & 8'h7F)
            8'h22:   return m_pl;
            8'h23:   return m_ph;
            8'h2C:   return m_al;
            8'h2D:   return m_ah;
            default: return 8'h00;
        endcase
    endfunction

    always @(negedge imu.SS_n) begin
        fall_n = 0;
        rx_sh  = 16'h0000;
        t_ss   = $time;
        ssn_falls++;
    end

    always @(posedge imu.SCLK) if (imu.SS_n === 1'b0) rx_sh = {rx_sh[14:0], imu.MOSI};

    always @(negedge imu.SCLK) begin
        if (imu.SS_n === 1'b0) begin
            fall_n++;
            if (fall_n == 1) t_f1 = $time;
            if (fall_n == 2) t_f2 = $time;
            if (fall_n == 9) tx_b = lookup(rx_sh[7:0]);
            if (fall_n >= 9 && fall_n <= 16) imu.MISO = tx_b[16-fall_n];
            else imu.MISO = 1'b0;
        end
    end

    always @(posedge imu.SS_n) frames.push_back(rx_sh);

    // Output monitors sampled mid-cycle
    int          vld_cnt = 0;
    int          bad_chg = 0;
    logic [15:0] prev_p, prev_a;
    always @(negedge clk) begin
        if (imu.vld === 1'b1) vld_cnt++;
        if (rst_n && !imu.vld && ((imu.ptch_rt !== prev_p) || (imu.AZ !== prev_a))) bad_chg++;
        prev_p = imu.ptch_rt;
        prev_a = imu.AZ;
    end

    task automatic wait_frames(input int n, input int budget);
        int k = 0;
        while (frames.size() < n && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        check_val("wait_frames", 32'(frames.size() >= n), 32'd1);
    endtask

    task automatic wait_vld(input int n, input int budget);
        int k = 0;
        while (vld_cnt < n && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        check_val("wait_vld", 32'(vld_cnt), 32'(n));
    endtask

    task automatic pulse_int(input int len);
        @(negedge clk) imu.INT = 1'b1;
        repeat (len) @(negedge clk);
        imu.INT = 1'b0;
    endtask

    task automatic check_frames(input string tag, input int base, input logic [15:0] w0,
                                input logic [15:0] w1, input logic [15:0] w2, input logic [15:0] w3);
        logic [15:0] exp_w[4];
        exp_w = '{w0, w1, w2, w3};
        for (int i = 0; i < 4; i++)
            check_val($sformatf("%s_%0d", tag, i), 32'(frames[base+i]), 32'(exp_w[i]));
    endtask

    int base_f;

    initial begin
        imu.INT  = 1'b0;
        imu.MISO = 1'b0;
        m_pl = 8'h34; m_ph = 8'h12; m_al = 8'h78; m_ah = 8'h56;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_ss_n", 32'(imu.SS_n), 32'd1);
        check_val("rst_sclk", 32'(imu.SCLK), 32'd1);
        check_val("rst_vld", 32'(imu.vld), 32'd0);
        check_val("rst_ptch", 32'(imu.ptch_rt), 32'h0);
        check_val("rst_az", 32'(imu.AZ), 32'h0);
        frames.delete();
        ssn_falls = 0;
        vld_cnt   = 0;
        @(negedge clk) rst_n = 1'b1;

        // Power-up wait then configuration
        repeat (256) @(posedge clk);
        #1 check_val("init_quiet", 32'(ssn_falls), 32'd0);
        wait_frames(4, 3000);
        check_frames("cfg", 0, 16'h0D02, 16'h1053, 16'h1150, 16'h1460);
        check_val("first_fall_clks", 32'((t_f1 - t_ss) / 10), 32'd8);
        check_val("sclk_period_clks", 32'((t_f2 - t_f1) / 10), 32'd32);
        check_val("cfg_no_vld", 32'(vld_cnt), 32'd0);

        // Single read
        repeat (20) @(posedge clk);
        pulse_int(4);
        wait_vld(1, 3000);
        check_val("rd_ptch", 32'(imu.ptch_rt), 32'h1234);
        check_val("rd_az", 32'(imu.AZ), 32'h5678);
        check_val("rd_vld_one_cycle", 32'(imu.vld), 32'd0);
        check_frames("rd_cmd", 4, 16'hA200, 16'hA300, 16'hAC00, 16'hAD00);
        check_val("rd_no_early_change", 32'(bad_chg), 32'd0);

        // INT held high: back-to-back sequences
        base_f = frames.size();
        @(negedge clk) imu.INT = 1'b1;
        wait_vld(3, 4500);
        check_val("held_frames", 32'(frames.size()), 32'(base_f + 8));
        imu.INT = 1'b0;
        wait_vld(4, 3000);
        repeat (2500) @(posedge clk);
        #1;
        check_val("held_vld_total", 32'(vld_cnt), 32'd4);
        check_val("held_frames_total", 32'(frames.size()), 32'(base_f + 12));

        // INT pulsed during RD_PH, with sign/byte-order data
        m_pl = 8'h00; m_ph = 8'hF0; m_al = 8'hFF; m_ah = 8'h80;
        base_f = frames.size();
        pulse_int(4);
        wait_frames(base_f + 1, 800);
        repeat (100) @(negedge clk);
        pulse_int(4);
        wait_vld(5, 3000);
        check_val("sign_ptch", 32'(imu.ptch_rt), 32'hF000);
        check_val("sign_az", 32'(imu.AZ), 32'h80FF);
        repeat (2500) @(posedge clk);
        #1;
        check_val("ph_pulse_vld", 32'(vld_cnt), 32'd5);
        check_val("ph_pulse_frames", 32'(frames.size()), 32'(base_f + 4));
        check_val("no_bad_change", 32'(bad_chg), 32'd0);

        // Reset during the AZ-low transaction
        base_f = frames.size();
        pulse_int(4);
        wait_frames(base_f + 2, 1600);
        begin
            int k = 0;
            while (imu.SS_n !== 1'b0 && k < 100) begin
                @(posedge clk); #1;
                k++;
            end
        end
        check_val("al_started", 32'(imu.SS_n), 32'd0);
        repeat (80) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_val("async_ss_n", 32'(imu.SS_n), 32'd1);
        check_val("async_sclk", 32'(imu.SCLK), 32'd1);
        frames.delete();
        ssn_falls = 0;
        repeat (3) @(negedge clk);
        check_val("mid_rst_ptch", 32'(imu.ptch_rt), 32'h0);
        check_val("mid_rst_az", 32'(imu.AZ), 32'h0);
        check_val("mid_rst_vld", 32'(imu.vld), 32'd0);
        rst_n = 1'b1;
        wait_frames(4, 3000);
        check_frames("recfg", 0, 16'h0D02, 16'h1053, 16'h1150, 16'h1460);
        check_val("recfg_no_vld", 32'(vld_cnt), 32'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
